// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron MAC datapath: format defaults, FSM state
// encoding and the sign-magnitude saturating adder used by the accumulator.
package neuron_pkg;

  localparam int WIDTH_DEF    = 16;
  localparam int INT_BITS_DEF = 6;

  // Widest magnitude the adder helper handles; callers zero-extend into it.
  localparam int SM_MAXW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic               sgn;
    logic [SM_MAXW-1:0] mag;
    logic               ovf;
  } sm_sum_t;

  // Sign-magnitude add of two values whose magnitudes occupy mag_bits bits.
  // Saturates the magnitude to all-ones on overflow (sign kept) and never
  // returns negative zero.
  function automatic sm_sum_t sm_sat_add(
    input logic               a_sgn,
    input logic [SM_MAXW-1:0] a_mag,
    input logic               b_sgn,
    input logic [SM_MAXW-1:0] b_mag,
    input int                 mag_bits
  );
    logic [SM_MAXW:0]   sum;
    logic [SM_MAXW-1:0] limit;
    sm_sum_t            r;
    limit = {SM_MAXW{1'b1}} >> (SM_MAXW - mag_bits);
    sum   = {1'b0, a_mag} + {1'b0, b_mag};
    r     = '0;
    if (a_sgn == b_sgn) begin
      r.sgn = a_sgn;
      if (sum > {1'b0, limit}) begin
        r.mag = limit;
        r.ovf = 1'b1;
      end else begin
        r.mag = sum[SM_MAXW-1:0];
        r.ovf = 1'b0;
      end
    end else if (a_mag >= b_mag) begin
      r.sgn = a_sgn;
      r.mag = a_mag - b_mag;
      r.ovf = 1'b0;
    end else begin
      r.sgn = b_sgn;
      r.mag = b_mag - a_mag;
      r.ovf = 1'b0;
    end
    if (r.mag == {SM_MAXW{1'b0}}) begin
      r.sgn = 1'b0;
    end else begin
      r.sgn = r.sgn;
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_mac_sequencer_mult.sv
// Sign-magnitude fixed-point multiplier. The fraction bits below the output
// LSB are truncated; ovf flags a product magnitude that does not fit.
module neuron_mac_sequencer_mult #(
  parameter int WIDTH     = 16,
  parameter int INT_BITS  = 6,
  parameter int FRAC_BITS = WIDTH - INT_BITS
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int MAG_W  = WIDTH - 1;
  localparam int PROD_W = 2 * MAG_W;

  logic [PROD_W-1:0] full_s;
  logic [PROD_W-1:0] shifted_s;

  // Full-precision magnitude product, realigned to the output fraction.
  always_comb begin
    full_s    = PROD_W'(a[MAG_W-1:0]) * PROD_W'(b[MAG_W-1:0]);
    shifted_s = full_s >> FRAC_BITS;
    ovf       = |shifted_s[PROD_W-1:MAG_W];
    result    = {a[WIDTH-1] ^ b[WIDTH-1], shifted_s[MAG_W-1:0]};
  end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Neuron evaluation y = bias + sum(x[i]*w[i]) in sign-magnitude fixed point,
// using a single multiplier time-shared across the input pairs, one product
// per cycle, with saturating accumulation and a sticky overflow flag.
module neuron_mac_sequencer
  import neuron_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int INT_BITS = INT_BITS_DEF,
  parameter int N_INPUTS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_INPUTS*WIDTH-1:0] x_in,
  input  logic [N_INPUTS*WIDTH-1:0] w_in,
  input  logic [WIDTH-1:0]          bias,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          y_out,
  output logic                      ovf
);

  localparam int FRAC_BITS = WIDTH - INT_BITS;
  localparam int MAG_W     = WIDTH - 1;
  localparam int IDX_W     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  state_t                    state_r;
  state_t                    state_s;
  logic [N_INPUTS*WIDTH-1:0] x_r;
  logic [N_INPUTS*WIDTH-1:0] w_r;
  logic [WIDTH-1:0]          acc_r;
  logic [IDX_W-1:0]          idx_r;
  logic                      ovf_acc_r;
  logic                      busy_r;
  logic                      done_r;
  logic [WIDTH-1:0]          y_out_r;
  logic                      ovf_r;

  logic [WIDTH-1:0]          x_sel_s;
  logic [WIDTH-1:0]          w_sel_s;
  logic [WIDTH-1:0]          prod_s;
  logic                      prod_ovf_s;
  logic [MAG_W-1:0]          prod_mag_s;
  sm_sum_t                   add_s;
  logic [WIDTH-1:0]          acc_next_s;
  logic                      mac_ovf_s;

  neuron_mac_sequencer_mult #(
    .WIDTH     (WIDTH),
    .INT_BITS  (INT_BITS),
    .FRAC_BITS (FRAC_BITS)
  ) u_mult (
    .a      (x_sel_s),
    .b      (w_sel_s),
    .result (prod_s),
    .ovf    (prod_ovf_s)
  );

  // Operand select, overflow substitution and saturating accumulate.
  always_comb begin
    x_sel_s    = x_r[int'(idx_r)*WIDTH +: WIDTH];
    w_sel_s    = w_r[int'(idx_r)*WIDTH +: WIDTH];
    prod_mag_s = prod_ovf_s ? {MAG_W{1'b1}} : prod_s[MAG_W-1:0];
    add_s      = sm_sat_add(acc_r[WIDTH-1], SM_MAXW'(acc_r[MAG_W-1:0]),
                            prod_s[WIDTH-1], SM_MAXW'(prod_mag_s), MAG_W);
    acc_next_s = {add_s.sgn, add_s.mag[MAG_W-1:0]};
    // Any magnitude bit beyond the field would be a lost value; treat as overflow.
    mac_ovf_s  = prod_ovf_s | add_s.ovf | (|add_s.mag[SM_MAXW-1:MAG_W]);
  end

  // Next-state logic: one MAC cycle per input pair, then a single DONE cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_MAC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (idx_r == IDX_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_MAC;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture on accept, accumulation while in MAC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r       <= '0;
      w_r       <= '0;
      acc_r     <= '0;
      idx_r     <= '0;
      ovf_acc_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            x_r       <= x_in;
            w_r       <= w_in;
            acc_r     <= bias;
            idx_r     <= '0;
            ovf_acc_r <= 1'b0;
          end else begin
            idx_r     <= idx_r;
          end
        end
        ST_MAC: begin
          acc_r     <= acc_next_s;
          ovf_acc_r <= ovf_acc_r | mac_ovf_s;
          idx_r     <= idx_r + IDX_W'(1);
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Registered status and result; result is published as DONE is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      y_out_r <= '0;
      ovf_r   <= 1'b0;
    end else begin
      busy_r <= (state_s != ST_IDLE);
      if (state_r == ST_DONE) begin
        done_r  <= 1'b1;
        y_out_r <= acc_r;
        ovf_r   <= ovf_acc_r;
      end else begin
        done_r  <= 1'b0;
      end
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign y_out = y_out_r;
  assign ovf   = ovf_r;

endmodule
